// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: parses SYNC/CMD/LEN/payload/CHK packets from a UART byte stream
// and holds each validated frame behind a valid/ack handshake with a payload read port.
module uart_frame_decoder #(
    parameter int unsigned  MAX_PAYLOAD    = 16,
    parameter logic [7:0]   SYNC_BYTE      = 8'hA5,
    parameter int unsigned  TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned AW             = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_ready_i,
    input  logic          rx_error_i,
    output logic          frame_valid_o,
    input  logic          frame_ack_i,
    output logic [7:0]    cmd_o,
    output logic [7:0]    len_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    output logic          frame_err_o,
    output logic [1:0]    err_code_o,
    output logic          overrun_o
);
    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_CHK     = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    logic [2:0]  r_state;
    logic [7:0]  r_acc;
    logic [7:0]  r_cmd;
    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [31:0] r_cnt;
    logic [7:0]  r_cmd_out;
    logic [7:0]  r_len_out;
    logic        r_frame_err;
    logic [1:0]  r_err_code;
    logic        r_overrun;
    logic [7:0]  r_mem [MAX_PAYLOAD];
    logic        w_mid;
    logic        w_tmo;

    assign w_mid = (r_state == S_CMD) || (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // An arriving byte beats a timeout landing on the same cycle.
    assign w_tmo = w_mid && (TIMEOUT_CYCLES != 0) && !rx_ready_i && (r_cnt == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_SYNC;
            r_acc       <= '0;
            r_cmd       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_cmd_out   <= '0;
            r_len_out   <= '0;
            r_frame_err <= 1'b0;
            r_err_code  <= 2'b00;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_cnt       <= (w_mid && !rx_ready_i) ? r_cnt + 32'd1 : '0;
            if (w_mid && (rx_error_i || w_tmo)) begin
                r_frame_err <= 1'b1;
                r_err_code  <= rx_error_i ? 2'b00 : 2'b11;
                r_state     <= S_SYNC;
            end else if (rx_ready_i) begin
                case (r_state)
                    S_SYNC: if (rx_data_i == SYNC_BYTE) begin
                        r_acc   <= '0;
                        r_state <= S_CMD;
                    end
                    S_CMD: begin
                        r_cmd   <= rx_data_i;
                        r_acc   <= r_acc ^ rx_data_i;
                        r_state <= S_LEN;
                    end
                    S_LEN: if (32'(rx_data_i) > MAX_PAYLOAD) begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= 2'b10;
                        r_state     <= S_SYNC;
                    end else begin
                        r_len   <= rx_data_i;
                        r_acc   <= r_acc ^ rx_data_i;
                        r_idx   <= '0;
                        r_state <= (rx_data_i == 8'd0) ? S_CHK : S_PAYLOAD;
                    end
                    S_PAYLOAD: begin
                        r_acc   <= r_acc ^ rx_data_i;
                        r_idx   <= r_idx + 8'd1;
                        r_state <= (r_idx == r_len - 8'd1) ? S_CHK : S_PAYLOAD;
                    end
                    S_CHK: if (rx_data_i == r_acc) begin
                        r_cmd_out <= r_cmd;
                        r_len_out <= r_len;
                        r_state   <= S_HOLD;
                    end else begin
                        r_frame_err <= 1'b1;
                        r_err_code  <= 2'b01;
                        r_state     <= S_SYNC;
                    end
                    S_HOLD: r_overrun <= 1'b1;
                    default: r_state <= S_SYNC;
                endcase
            end
            if (r_state == S_HOLD && frame_ack_i)
                r_state <= S_SYNC;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == S_PAYLOAD && rx_ready_i && !rx_error_i)
            r_mem[r_idx[AW-1:0]] <= rx_data_i;
    end

    assign frame_valid_o = (r_state == S_HOLD);
    assign cmd_o         = r_cmd_out;
    assign len_o         = r_len_out;
    assign rd_data_o     = r_mem[rd_addr_i];
    assign frame_err_o   = r_frame_err;
    assign err_code_o    = r_err_code;
    assign overrun_o     = r_overrun;
endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder: directed scenario tasks with hand-computed expectations.
module tb_uart_frame_decoder;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rx_ready_i = 1'b0;
    logic       rx_error_i = 1'b0;
    logic       frame_valid_o;
    logic       frame_ack_i = 1'b0;
    logic [7:0] cmd_o;
    logic [7:0] len_o;
    logic [3:0] rd_addr_i = '0;
    logic [7:0] rd_data_o;
    logic       frame_err_o;
    logic [1:0] err_code_o;
    logic       overrun_o;
    int         n_cmp = 0;
    int         n_err = 0;

    uart_frame_decoder #(.MAX_PAYLOAD(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(100)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i),
        .rx_error_i(rx_error_i), .frame_valid_o(frame_valid_o), .frame_ack_i(frame_ack_i),
        .cmd_o(cmd_o), .len_o(len_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .frame_err_o(frame_err_o), .err_code_o(err_code_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic send_byte(input logic [7:0] b);
        rx_data_i = b;
        rx_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rx_ready_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic ack();
        frame_ack_i = 1'b1;
        @(posedge clk_i);
        #1 frame_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #2;
        n_cmp++; if (frame_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", frame_valid_o); end
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", frame_err_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL rst_ovr: got %b want 0", overrun_o); end
        n_cmp++; if (err_code_o !== 2'b00) begin n_err++; $display("FAIL rst_code: got %b want 00", err_code_o); end
        n_cmp++; if (cmd_o !== 8'h00) begin n_err++; $display("FAIL rst_cmd: got %h want 00", cmd_o); end
        n_cmp++; if (len_o !== 8'h00) begin n_err++; $display("FAIL rst_len: got %h want 00", len_o); end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle(1);
    endtask

    task automatic test_good_frame();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        n_cmp++; if (frame_valid_o !== 1'b0) begin n_err++; $display("FAIL good_early_valid: got %b want 0", frame_valid_o); end
        send_byte(8'h65);
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL good_valid: got %b want 1", frame_valid_o); end
        n_cmp++; if (cmd_o !== 8'h10) begin n_err++; $display("FAIL good_cmd: got %h want 10", cmd_o); end
        n_cmp++; if (len_o !== 8'h02) begin n_err++; $display("FAIL good_len: got %h want 02", len_o); end
        rd_addr_i = 4'd0; #1;
        n_cmp++; if (rd_data_o !== 8'h33) begin n_err++; $display("FAIL good_pl0: got %h want 33", rd_data_o); end
        rd_addr_i = 4'd1; #1;
        n_cmp++; if (rd_data_o !== 8'h44) begin n_err++; $display("FAIL good_pl1: got %h want 44", rd_data_o); end
        ack();
        n_cmp++; if (frame_valid_o !== 1'b0) begin n_err++; $display("FAIL good_ack: got %b want 0", frame_valid_o); end
    endtask

    task automatic test_bad_chk_zero_len();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44); send_byte(8'h66);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL chk_err: got %b want 1", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b01) begin n_err++; $display("FAIL chk_code: got %b want 01", err_code_o); end
        n_cmp++; if (frame_valid_o !== 1'b0) begin n_err++; $display("FAIL chk_valid: got %b want 0", frame_valid_o); end
        idle(1);
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL chk_pulse: got %b want 0", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b01) begin n_err++; $display("FAIL chk_code_hold: got %b want 01", err_code_o); end
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL zl_valid: got %b want 1", frame_valid_o); end
        n_cmp++; if (cmd_o !== 8'h20) begin n_err++; $display("FAIL zl_cmd: got %h want 20", cmd_o); end
        n_cmp++; if (len_o !== 8'h00) begin n_err++; $display("FAIL zl_len: got %h want 00", len_o); end
        ack();
    endtask

    task automatic test_length_resync();
        send_byte(8'h00); send_byte(8'hFF);
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL garbage_err: got %b want 0", frame_err_o); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL len_err: got %b want 1", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b10) begin n_err++; $display("FAIL len_code: got %b want 10", err_code_o); end
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7E);
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL resync_valid: got %b want 1", frame_valid_o); end
        n_cmp++; if (len_o !== 8'h01) begin n_err++; $display("FAIL resync_len: got %h want 01", len_o); end
        rd_addr_i = 4'd0; #1;
        n_cmp++; if (rd_data_o !== 8'h7E) begin n_err++; $display("FAIL resync_pl0: got %h want 7e", rd_data_o); end
        ack();
    endtask

    task automatic test_timeout_line();
        send_byte(8'hA5); send_byte(8'h10);
        idle(99);
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b10) begin n_err++; $display("FAIL tmo_code_hold: got %b want 10", err_code_o); end
        idle(1);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b11) begin n_err++; $display("FAIL tmo_code: got %b want 11", err_code_o); end
        send_byte(8'hA5);
        rx_error_i = 1'b1;
        @(posedge clk_i);
        #1 rx_error_i = 1'b0;
        n_cmp++; if (frame_err_o !== 1'b1) begin n_err++; $display("FAIL line_err: got %b want 1", frame_err_o); end
        n_cmp++; if (err_code_o !== 2'b00) begin n_err++; $display("FAIL line_code: got %b want 00", err_code_o); end
        send_byte(8'hA5); send_byte(8'h10);
        idle(99);
        send_byte(8'h02);
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_byte_wins: got %b want 0", frame_err_o); end
        send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL tmo_byte_valid: got %b want 1", frame_valid_o); end
        ack();
    endtask

    task automatic test_overrun_hold();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44); send_byte(8'h65);
        send_byte(8'hA5);
        n_cmp++; if (overrun_o !== 1'b1) begin n_err++; $display("FAIL ovr_pulse: got %b want 1", overrun_o); end
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", frame_valid_o); end
        n_cmp++; if (cmd_o !== 8'h10) begin n_err++; $display("FAIL ovr_cmd: got %h want 10", cmd_o); end
        rd_addr_i = 4'd0; #1;
        n_cmp++; if (rd_data_o !== 8'h33) begin n_err++; $display("FAIL ovr_pl0: got %h want 33", rd_data_o); end
        idle(1);
        n_cmp++; if (overrun_o !== 1'b0) begin n_err++; $display("FAIL ovr_one_cycle: got %b want 0", overrun_o); end
        ack();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7E);
        n_cmp++; if (cmd_o !== 8'h01) begin n_err++; $display("FAIL ovr_next_cmd: got %h want 01", cmd_o); end
        rd_addr_i = 4'd0; #1;
        n_cmp++; if (rd_data_o !== 8'h7E) begin n_err++; $display("FAIL ovr_next_pl0: got %h want 7e", rd_data_o); end
        ack();
    endtask

    task automatic test_reset_mid_frame();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h33);
        rst_ni = 1'b0;
        #2;
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL rmid_err: got %b want 0", frame_err_o); end
        n_cmp++; if (cmd_o !== 8'h00) begin n_err++; $display("FAIL rmid_cmd: got %h want 00", cmd_o); end
        n_cmp++; if (len_o !== 8'h00) begin n_err++; $display("FAIL rmid_len: got %h want 00", len_o); end
        n_cmp++; if (frame_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b want 0", frame_valid_o); end
        #1 rst_ni = 1'b1;
        idle(1);
        n_cmp++; if (frame_err_o !== 1'b0) begin n_err++; $display("FAIL rmid_no_pulse: got %b want 0", frame_err_o); end
        send_byte(8'hA5); send_byte(8'h20); send_byte(8'h00); send_byte(8'h20);
        n_cmp++; if (frame_valid_o !== 1'b1) begin n_err++; $display("FAIL rmid_next_valid: got %b want 1", frame_valid_o); end
        n_cmp++; if (cmd_o !== 8'h20) begin n_err++; $display("FAIL rmid_next_cmd: got %h want 20", cmd_o); end
        ack();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk_zero_len();
        test_length_resync();
        test_timeout_line();
        test_overrun_hold();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
